// File: rtl/byte_lane_memory_pkg.sv
// mem_pkg: size and FSM encodings plus lane/alignment helpers shared by the byte-lane memory.
package mem_pkg;
  typedef enum logic [1:0] {SIZE_B, SIZE_H, SIZE_W, SIZE_D} size_t;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  function automatic logic [7:0] lane_enables(size_t s);
    return s == SIZE_B ? 8'h01 : s == SIZE_H ? 8'h03 : s == SIZE_W ? 8'h0F : 8'hFF;
  endfunction
  function automatic logic [2:0] align_mask(size_t s);
    return s == SIZE_B ? 3'd0 : s == SIZE_H ? 3'd1 : s == SIZE_W ? 3'd3 : 3'd7;
  endfunction
endpackage

// File: rtl/byte_lane_memory_if.sv
// byte_lane_memory_if: req/ready/valid bus between the core and the byte-lane memory.
interface byte_lane_memory_if #(parameter int DATA_WIDTH = 32, parameter int ADDR_WIDTH = 10);
  import mem_pkg::*;
  logic req, ready, we, zero_ext, valid, misaligned;
  size_t size;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] wdata, rdata;
  modport master(output req, we, size, zero_ext, address, wdata, input ready, rdata, valid, misaligned);
  modport slave(input req, we, size, zero_ext, address, wdata, output ready, rdata, valid, misaligned);
endinterface

// File: rtl/byte_lane_memory_ram.sv
// byte_ram: byte array with per-lane write enables and an asynchronous full-width read.
module byte_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter string MEM_INIT_FILE = ""
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);
  localparam int NB = DATA_WIDTH / 8;
  logic [7:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] lane_addr [NB];
  for (genvar b = 0; b < NB; b++) begin : g_lane
    assign lane_addr[b] = addr + ADDR_WIDTH'(b);
    assign rdata[8*b +: 8] = mem[lane_addr[b]];
  end
  always_ff @(posedge clk)
    for (int i = 0; i < NB; i++)
      if (we && be[i]) mem[lane_addr[i]] <= wdata[8*i +: 8];
endmodule

// File: rtl/byte_lane_memory.sv
// byte_lane_memory: sub-word data memory with wait-stated loads, extension and misalignment rejection.
module byte_lane_memory
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int WAIT_STATES = 0,
  parameter string MEM_INIT_FILE = ""
) (
  input logic clk,
  input logic rst_n,
  byte_lane_memory_if.slave bus
);
  localparam int NB = DATA_WIDTH / 8;
  state_t state;
  logic [2:0] cnt;
  size_t size_q, sz;
  logic zx_q, zx, idle, accept, mis, sign;
  logic [ADDR_WIDTH-1:0] addr_q, addr;
  logic ready_q, valid_q, mis_q;
  logic [DATA_WIDTH-1:0] rdata_q, raw, keep, loaded;
  logic [NB-1:0] be;
  // In IDLE the array is addressed straight from the bus so stores and zero-wait loads finish on the accepting edge
  always_comb begin
    idle = state == IDLE;
    accept = idle && bus.req && rst_n;
    sz = idle ? bus.size : size_q;
    zx = idle ? bus.zero_ext : zx_q;
    addr = idle ? bus.address : addr_q;
    be = NB'(lane_enables(bus.size));
    mis = (bus.size == SIZE_D && DATA_WIDTH == 32) || (bus.address[2:0] & align_mask(bus.size)) != 3'd0;
    keep = sz == SIZE_B ? DATA_WIDTH'(8'hFF) : sz == SIZE_H ? DATA_WIDTH'(16'hFFFF) :
           sz == SIZE_W ? DATA_WIDTH'(32'hFFFF_FFFF) : '1;
    sign = !zx && (sz == SIZE_B ? raw[7] : sz == SIZE_H ? raw[15] : sz == SIZE_W ? raw[31] : 1'b0);
    loaded = (raw & keep) | (sign ? ~keep : '0);
  end
  byte_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .MEM_INIT_FILE(MEM_INIT_FILE)) u_ram (
    .clk(clk), .we(accept && bus.we && !mis), .be(be), .addr(addr), .wdata(bus.wdata), .rdata(raw)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= 3'd0;
      size_q <= SIZE_B;
      zx_q <= 1'b0;
      addr_q <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      mis_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          valid_q <= 1'b0;
          mis_q <= 1'b0;
          if (bus.req) begin
            size_q <= bus.size;
            zx_q <= bus.zero_ext;
            addr_q <= bus.address;
            ready_q <= 1'b0;
            if (mis || bus.we || WAIT_STATES == 0) begin
              state <= RESP;
              valid_q <= 1'b1;
              mis_q <= mis;
              rdata_q <= (mis || bus.we) ? '0 : loaded;
            end else begin
              state <= WAIT;
              cnt <= 3'(WAIT_STATES);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            state <= RESP;
            valid_q <= 1'b1;
            rdata_q <= loaded;
          end
        end
        RESP: begin
          state <= IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
          mis_q <= 1'b0;
        end
        default: begin
          state <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end
  assign bus.ready = ready_q;
  assign bus.valid = valid_q;
  assign bus.misaligned = mis_q;
  assign bus.rdata = rdata_q;
endmodule

// File: tb/tb_byte_lane_memory.sv
// tb_byte_lane_memory: scoreboard bench for byte_lane_memory with WAIT_STATES = 3.
module tb_byte_lane_memory;
  import mem_pkg::*;
  typedef struct {
    logic [31:0] rdata;
    logic        mis;
    int          cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0, fails = 0, cyc = 0;
  exp_t q[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  byte_lane_memory_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) bus();
  byte_lane_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .WAIT_STATES(3), .MEM_INIT_FILE("")) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.valid) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_valid: got rdata %h with no request pending", bus.rdata);
      end else begin
        e = q.pop_front();
        check("rdata", bus.rdata, e.rdata);
        check("misaligned", 32'(bus.misaligned), 32'(e.mis));
        check("latency_cycle", cyc, e.cyc);
      end
    end
  end
  task automatic drain();
    for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL response_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask
  task automatic send(logic we, size_t sz, logic zx, logic [9:0] a, logic [31:0] wd,
                      logic [31:0] er, logic em, int lat);
    @(negedge clk);
    bus.req = 1'b1;
    bus.we = we;
    bus.size = sz;
    bus.zero_ext = zx;
    bus.address = a;
    bus.wdata = wd;
    for (int i = 0; i < 50 && !bus.ready; i++) @(negedge clk);
    if (!bus.ready) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got ready 0 expected 1");
    end else q.push_back('{er, em, cyc + lat});
    @(posedge clk);
    #1 bus.req = 1'b0;
    drain();
  endtask
  initial begin
    int a0, n;
    bus.req = 1'b0; bus.we = 1'b0; bus.size = SIZE_B; bus.zero_ext = 1'b0;
    bus.address = '0; bus.wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(bus.ready), 32'd1);
    check("reset_valid", 32'(bus.valid), 32'd0);
    check("reset_misaligned", 32'(bus.misaligned), 32'd0);
    check("reset_rdata", bus.rdata, 32'd0);
    rst_n = 1'b1;
    send(1, SIZE_W, 0, 10'h010, 32'hDEADBEEF, 32'h0, 0, 1);
    send(0, SIZE_W, 0, 10'h010, 32'h0, 32'hDEADBEEF, 0, 4);
    send(0, SIZE_B, 0, 10'h013, 32'h0, 32'hFFFFFFDE, 0, 4);
    send(0, SIZE_B, 1, 10'h013, 32'h0, 32'h000000DE, 0, 4);
    send(0, SIZE_H, 0, 10'h010, 32'h0, 32'hFFFFBEEF, 0, 4);
    send(0, SIZE_H, 1, 10'h012, 32'h0, 32'h0000DEAD, 0, 4);
    send(1, SIZE_B, 0, 10'h011, 32'hAAAAAA55, 32'h0, 0, 1);
    send(0, SIZE_W, 0, 10'h010, 32'h0, 32'hDEAD55EF, 0, 4);
    send(1, SIZE_H, 0, 10'h011, 32'h00001234, 32'h0, 1, 1);
    send(0, SIZE_W, 0, 10'h010, 32'h0, 32'hDEAD55EF, 0, 4);
    send(0, SIZE_W, 0, 10'h012, 32'h0, 32'h0, 1, 1);
    send(0, SIZE_D, 0, 10'h010, 32'h0, 32'h0, 1, 1);
    send(1, SIZE_W, 0, 10'h012, 32'hFFFFFFFF, 32'h0, 1, 1);
    send(1, SIZE_H, 0, 10'h012, 32'hFFFF1234, 32'h0, 0, 1);
    send(0, SIZE_W, 1, 10'h010, 32'h0, 32'h123455EF, 0, 4);
    send(0, SIZE_B, 0, 10'h010, 32'h0, 32'hFFFFFFEF, 0, 4);
    send(0, SIZE_B, 0, 10'h011, 32'h0, 32'h00000055, 0, 4);
    send(1, SIZE_W, 0, 10'h3FC, 32'h80000001, 32'h0, 0, 1);
    send(0, SIZE_H, 0, 10'h3FE, 32'h0, 32'hFFFF8000, 0, 4);
    send(0, SIZE_B, 1, 10'h3FC, 32'h0, 32'h00000001, 0, 4);
    // back-to-back loads with req held high
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.size = SIZE_W; bus.zero_ext = 1'b0; bus.address = 10'h010;
    check("b2b_first_ready", 32'(bus.ready), 32'd1);
    a0 = cyc;
    q.push_back('{32'h123455EF, 1'b0, cyc + 4});
    @(negedge clk);
    n = 0;
    while (!bus.ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("ready_low_cycles", n, 4);
    check("reaccept_spacing", cyc - a0, 5);
    q.push_back('{32'h123455EF, 1'b0, cyc + 4});
    @(posedge clk);
    #1 bus.req = 1'b0;
    drain();
    // reset while the load sits in WAIT must drop its response
    @(negedge clk);
    bus.req = 1'b1; bus.address = 10'h010;
    @(posedge clk);
    #1 bus.req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("wait_ready_low", 32'(bus.ready), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_ready", 32'(bus.ready), 32'd1);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_reset_ready", 32'(bus.ready), 32'd1);
    check("post_reset_valid", 32'(bus.valid), 32'd0);
    send(0, SIZE_W, 0, 10'h010, 32'h0, 32'h123455EF, 0, 4);
    send(0, SIZE_W, 0, 10'h3FC, 32'h0, 32'h80000001, 0, 4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
